// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fronted by a small TX queue. The host pushes payload words
//   into the FIFO. The serializer drains the FIFO and sends one frame per entry.
//   A frame is a start bit, DATA_BITS data bits (LSB first), an optional parity
//   bit and STOP_BITS stop bits. Each bit lasts BAUD_DIV clocks. When more data
//   is queued, frames follow each other with no idle gap.
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst_n     in   synchronous active-low reset; empties FIFO, aborts frame
//   wr_en     in   push wr_data (dropped while full=1)
//   wr_data   in   [DATA_BITS-1:0] frame payload
//   full      out  FIFO holds FIFO_DEPTH entries (registered)
//   fifo_cnt  out  [$clog2(FIFO_DEPTH+1)-1:0] queued entries, excludes frame in flight
//   TX        out  serial line, idle high, registered
//   busy      out  a frame is in progress
//   tx_done   out  one-clock pulse when the last stop bit of a frame completes
//
// FSM states
//   state   | meaning
//   S_IDLE  | line idle high, waiting for a queued entry
//   S_START | start bit (low) being sent
//   S_DATA  | data bits being sent, LSB first
//   S_PAR   | parity bit being sent (only when PARITY != 0)
//   S_STOP  | stop bit(s) being sent; may chain straight into the next frame

module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_DIV   = 2605,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [DATA_BITS-1:0]              wr_data,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
    output logic                              TX,
    output logic                              busy,
    output logic                              tx_done
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_PAR   = (PARITY == 1);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 4) begin : g_bad_baud_div
        $error("uart_tx_fifo: BAUD_DIV must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    // ------------------------------------------------------------------
    // TX queue
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt_next;
    logic                 wr_acc;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    // full is registered, so a pop in the same cycle cannot admit a write
    // that arrives while full=1.
    assign wr_acc   = wr_en && !full;
    assign head     = mem[rd_ptr];
    // XOR of the data gives the even-parity bit; odd parity inverts it.
    assign head_par = (^head) ^ ODD_PAR;

    always_comb begin
        cnt_next = fifo_cnt;
        case ({wr_acc, pop})
            2'b10:   cnt_next = fifo_cnt + CNT_W'(1);
            2'b01:   cnt_next = fifo_cnt - CNT_W'(1);
            default: cnt_next = fifo_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            full     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= cnt_next;
            full     <= (cnt_next == FULL_CNT);
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_bit, par_n;
    logic                 tx_n;
    logic                 done_n;
    logic                 bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n = state;
        baud_n  = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        par_n   = par_bit;
        tx_n    = TX;
        done_n  = 1'b0;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = head_par;
                    bit_n   = '0;
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = S_DATA;
                    tx_n    = shift_reg[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PAR;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        shift_n = {1'b0, shift_reg[DATA_BITS-1:1]};
                        // The bit after the current one is shift_reg[1].
                        tx_n    = shift_reg[1];
                    end
                end
            end

            S_PAR: begin
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_n = 1'b1;
                        bit_n  = '0;
                        // Chain straight into the next frame so the line
                        // never idles between queued entries.
                        if (fifo_cnt != '0) begin
                            pop     = 1'b1;
                            shift_n = head;
                            par_n   = head_par;
                            state_n = S_START;
                            tx_n    = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
                bit_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            TX        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            TX        <= tx_n;
            tx_done   <= done_n;
        end
    end

endmodule
